// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO: depth, pointer/count widths and FSM state encodings.
package fifo_pkg;

  localparam int unsigned Depth = 8;
  localparam int unsigned PtrW  = 3;
  localparam int unsigned CntW  = 4;

  typedef enum logic [2:0] {
    StInit    = 3'b000,
    StWrite   = 3'b001,
    StRead    = 3'b010,
    StWrError = 3'b011,
    StRdError = 3'b100
  } state_e;

endpackage

// File: rtl/fifo_state_ctrl_if.sv
// Handshake bundle between fifo_state_ctrl and its environment (requests, fifo_cal results, status).
interface fifo_state_ctrl_if;
  import fifo_pkg::*;

  logic            wr_en;
  logic            rd_en;
  logic [PtrW-1:0] next_head;
  logic [PtrW-1:0] next_tail;
  logic [CntW-1:0] next_data_count;
  logic [2:0]      state;
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [CntW-1:0] data_count;
  logic            full;
  logic            empty;
  logic            wr_ack;
  logic            wr_err;
  logic            rd_ack;
  logic            rd_err;

  modport master (
    output wr_en, rd_en, next_head, next_tail, next_data_count,
    input  state, head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, rd_en, next_head, next_tail, next_data_count,
    output state, head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/fifo_ns.sv
// Combinational next-state function of the FIFO FSM; independent of the current state.
module fifo_ns
  import fifo_pkg::*;
(
  input  logic            i_wr_en,
  input  logic            i_rd_en,
  input  logic [CntW-1:0] i_next_data_count,
  output state_e          o_next_state
);

  always_comb begin
    o_next_state = StInit;
    if (i_wr_en && !i_rd_en) begin
      o_next_state = (i_next_data_count == CntW'(Depth)) ? StWrError : StWrite;
    end else if (!i_wr_en && i_rd_en) begin
      o_next_state = (i_next_data_count == '0) ? StRdError : StRead;
    end
  end

endmodule

// File: rtl/fifo_state_ctrl.sv
// FIFO control stage: state register, gated commit of fifo_cal pointers/count, status decode.
module fifo_state_ctrl
  import fifo_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  fifo_state_ctrl_if.slave bus
);

  logic [2:0]      r_state;
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_data_count;
  state_e          w_next_state;

  fifo_ns u_fifo_ns (
    .i_wr_en           (bus.wr_en),
    .i_rd_en           (bus.rd_en),
    .i_next_data_count (bus.next_data_count),
    .o_next_state      (w_next_state)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StInit;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Only the state that owns a pointer commits it, so undriven next_* values never leak in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_data_count <= '0;
    end else begin
      if (r_state == StWrite) begin
        r_tail       <= bus.next_tail;
        r_data_count <= bus.next_data_count;
      end
      if (r_state == StRead) begin
        r_head       <= bus.next_head;
        r_data_count <= bus.next_data_count;
      end
    end
  end

  always_comb begin
    bus.wr_ack = 1'b0;
    bus.wr_err = 1'b0;
    bus.rd_ack = 1'b0;
    bus.rd_err = 1'b0;
    case (r_state)
      StWrite:   bus.wr_ack = 1'b1;
      StRead:    bus.rd_ack = 1'b1;
      StWrError: bus.wr_err = 1'b1;
      StRdError: bus.rd_err = 1'b1;
      default:   ;
    endcase
  end

  assign bus.state      = r_state;
  assign bus.head       = r_head;
  assign bus.tail       = r_tail;
  assign bus.data_count = r_data_count;
  assign bus.full       = (r_data_count == CntW'(Depth));
  assign bus.empty      = (r_data_count == '0);

endmodule

// File: tb/tb_fifo_state_ctrl.sv
// Closed-loop bench: fifo_cal stand-in, occupancy/pointer model, per-cycle compare plus literal pins.
module tb_fifo_state_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fifo_state_ctrl_if bus ();

  fifo_state_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // fifo_cal stand-in: advance the pointer/count owned by the current state.
  always_comb begin
    bus.next_head       = bus.head;
    bus.next_tail       = bus.tail;
    bus.next_data_count = bus.data_count;
    if (bus.state == 3'd1) begin
      bus.next_tail       = bus.tail + 3'd1;
      bus.next_data_count = bus.data_count + 4'd1;
    end else if (bus.state == 3'd2) begin
      bus.next_head       = bus.head + 3'd1;
      bus.next_data_count = bus.data_count - 4'd1;
    end
  end

  // Model: pending operation (0 idle, 1 write, 2 read, 3 write error, 4 read error).
  int m_op, m_count, m_head, m_tail;

  task automatic model_reset();
    m_op = 0; m_count = 0; m_head = 0; m_tail = 0;
  endtask

  task automatic model_edge(input bit w, input bit r);
    if (m_op == 1) begin
      m_count++;
      m_tail = (m_tail + 1) % 8;
    end else if (m_op == 2) begin
      m_count--;
      m_head = (m_head + 1) % 8;
    end
    if (w && !r)      m_op = (m_count == 8) ? 3 : 1;
    else if (!w && r) m_op = (m_count == 0) ? 4 : 2;
    else              m_op = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state", int'(bus.state), m_op);
    chk("head", int'(bus.head), m_head);
    chk("tail", int'(bus.tail), m_tail);
    chk("data_count", int'(bus.data_count), m_count);
    chk("full", int'(bus.full), int'(m_count == 8));
    chk("empty", int'(bus.empty), int'(m_count == 0));
    chk("wr_ack", int'(bus.wr_ack), int'(m_op == 1));
    chk("rd_ack", int'(bus.rd_ack), int'(m_op == 2));
    chk("wr_err", int'(bus.wr_err), int'(m_op == 3));
    chk("rd_err", int'(bus.rd_err), int'(m_op == 4));
  endtask

  task automatic step(input bit w, input bit r);
    bus.wr_en = w;
    bus.rd_en = r;
    @(posedge clk);
    model_edge(w, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    model_reset();
    do_reset();

    // Reset then idle.
    repeat (3) step(1'b0, 1'b0);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_count", int'(bus.data_count), 0);

    // Fill past full.
    repeat (9) step(1'b1, 1'b0);
    chk("fill_wr_err", int'(bus.wr_err), 1);
    chk("fill_count", int'(bus.data_count), 8);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_tail", int'(bus.tail), 0);

    // Drain past empty.
    repeat (9) step(1'b0, 1'b1);
    chk("drain_rd_err", int'(bus.rd_err), 1);
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_head", int'(bus.head), 0);

    // Simultaneous requests at count 3 are a no-op.
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    chk("both_state", int'(bus.state), 0);
    chk("both_count", int'(bus.data_count), 3);

    // Back-to-back write 2, read 1, write 1 from reset.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("b2b_count_mid", int'(bus.data_count), 1);
    step(1'b0, 1'b0);
    chk("b2b_count", int'(bus.data_count), 2);
    chk("b2b_tail", int'(bus.tail), 3);
    chk("b2b_head", int'(bus.head), 1);

    // Async reset mid-cycle while writing at count 5.
    do_reset();
    repeat (6) step(1'b1, 1'b0);
    chk("pre_rst_count", int'(bus.data_count), 5);
    chk("pre_rst_state", int'(bus.state), 1);
    #2;
    reset_n = 1'b0;
    bus.wr_en = 1'b0;
    model_reset();
    #1;
    chk("async_state", int'(bus.state), 0);
    chk("async_count", int'(bus.data_count), 0);
    chk("async_tail", int'(bus.tail), 0);
    chk("async_wr_ack", int'(bus.wr_ack), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    chk("post_rst_empty", int'(bus.empty), 1);
    step(1'b0, 1'b1);
    chk("post_rst_rd_err", int'(bus.rd_err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
